// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared constants for the instruction-fetch front end.
//   - FQ_INST_W  : instruction width carried through the fetch queue.
//   - FQ_PC_STEP : byte distance between sequential fetch addresses.
//   - INST_NOP   : canonical NOP (addi x0,x0,0) presented to decode when the
//                  queue head is empty.
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int          FQ_INST_W  = 32;
    localparam int          FQ_PC_STEP = 4;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO used as the fetch decoupling queue.
//   Head is read straight from the storage register (read-first), so a push
//   and a pop in the same cycle at count==1 hands out the old head and keeps
//   the new entry.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push, pop    : write din at tail / advance head (pop ignored when empty)
//   clear        : empty the FIFO this cycle, overriding push and pop
//   din, dout    : tail write data / current head data
//   count        : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count/pointers
    // already mark it empty, and resetting it would only cost flops.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end: owns the PC, issues one sequential imem read
//   per cycle while queue credit allows, tags each response with its PC and
//   buffers {pc, inst} in a DEPTH-entry FIFO read by decode via valid/ready.
//   A redirect flushes the queue, drops any arriving response and restarts
//   fetch at the (word-aligned) target.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   imem_req, imem_addr   : read request and word-aligned address
//   imem_rdata            : instruction, valid one cycle after imem_req
//   redirect, redirect_pc : flush and restart target (bits [1:0] ignored)
//   out_valid, out_ready  : head handshake towards decode
//   out_inst, out_pc      : head instruction (NOP when empty) and its PC
//   count                 : queue occupancy
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int              XLEN     = 32,
    parameter  int              DEPTH    = 4,
    parameter  logic [XLEN-1:0] RESET_PC = '0,
    localparam int              CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] count
);

    localparam int ENT_W = XLEN + FQ_INST_W;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  tag_q, tag_d;
    logic             inflight_q, inflight_d;
    logic             pop, push, issue;
    logic [CNT_W:0]   credit_used;
    logic [CNT_W-1:0] fifo_count;
    logic [ENT_W-1:0] fifo_dout;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;

    // Slots already spoken for: queued entries plus the response in flight,
    // minus the one decode is taking this cycle. Issue only while a slot is
    // guaranteed for the response arriving next cycle.
    assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue       = !rst && !redirect && (credit_used < (CNT_W+1)'(DEPTH));

    // A response landing in a redirect or reset cycle belongs to the old
    // stream and is dropped.
    assign push = inflight_q && !redirect && !rst;

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        if (redirect) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue) begin
            pc_d       = pc_q + XLEN'(FQ_PC_STEP);
            tag_d      = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   ({tag_q, imem_rdata}),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_inst  = out_valid ? fifo_dout[FQ_INST_W-1:0] : INST_NOP;
    assign out_pc    = fifo_dout[ENT_W-1:FQ_INST_W];
    assign count     = fifo_count;

    // The credit rule makes overflow impossible; catch any regression.
    assert property (@(posedge clk) disable iff (rst)
                     !(push && fifo_count == CNT_W'(DEPTH)));

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that replaces the single-entry IF/ID stall path with a decoupling queue. It owns the program counter, issues one sequential instruction-memory read per cycle while credit allows, and buffers returning {pc, instruction} pairs in a DEPTH-entry FIFO. Decode consumes entries through a valid/ready handshake. A redirect from decode or execute flushes the queue and restarts fetch at a new target.

## Interface
Parameters:
- XLEN, 32, PC/address width (32 or 64).
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 0, PC loaded on reset.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  XLEN  word-aligned fetch address; valid when imem_req=1.
- imem_rdata  in  32  instruction; valid exactly one cycle after the corresponding imem_req.
- redirect  in  1  flush queue and restart fetch.
- redirect_pc  in  XLEN  new fetch target; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head; ready low is the stall.
- out_inst  out  32  head instruction.
- out_pc  out  XLEN  PC of the head instruction.
- count  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- State: pc register, inflight flag (request issued last cycle), FIFO of DEPTH entries, each {pc, inst}.
- Pop: a pop occurs when out_valid && out_ready. The head advances at the clock edge.
- Issue rule: imem_req = !rst && !redirect && (count + inflight − pop < DEPTH). The pop credit is combinational from out_ready.
- On issue:
  - imem_addr = pc.
  - pc <= pc + 4, modulo 2^XLEN (wraps, no trap).
  - inflight <= 1. The issued pc is held in a side register for tagging the response.
- Response: when inflight=1 and there is no redirect this cycle, push {tag_pc, imem_rdata}. Push and pop may occur in the same cycle; count is unchanged.
- Redirect (highest priority):
  - FIFO emptied: count <= 0 and pointers reset.
  - Any response arriving this cycle is discarded.
  - imem_req is held 0.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - inflight <= 0.
  - A pop in the same cycle is allowed; the entry is discarded either way.
- Overflow: cannot occur by construction. An assertion checks that no push happens while count == DEPTH.
- Underflow: out_valid = (count != 0). When out_valid = 0, out_inst and out_pc are don't-care.
- Reset (any cycle, including mid-fetch):
  - pc <= RESET_PC, count <= 0, inflight <= 0.
  - A pending response is dropped.

## Timing
- Reset values: imem_req=0, out_valid=0, count=0. imem_addr, out_inst and out_pc are don't-care.
- First request is issued in the first cycle with rst=0, at RESET_PC.
- Fetch latency: request in cycle N, data in cycle N+1, written at the end of N+1, out_valid in N+2. There is no bypass.
- Throughput: with out_ready held high, one instruction per cycle sustained for any DEPTH ≥ 2.
- Redirect in cycle R:
  - out_valid = 0 in R+1.
  - Request to the target in R+1.
  - Target instruction visible in R+3 (3-cycle redirect penalty).
- Stall: with out_ready low, issue stops once count + inflight reaches DEPTH. No response is ever lost.

## Structure
- define.vh gains:
  - `FQ_INST_W` (32).
  - `FQ_PC_STEP` (4).
  - `INST_NOP` (32'h00000013), used by the decode control mux when out_valid = 0.
- One sub-module, fetch_fifo: synchronous FIFO parameterised by WIDTH and DEPTH.
  - Ports: push, pop, clear, din, dout, count.
  - Read-first: the head is registered; a same-cycle push/pop at count==1 is legal.
- fetch_queue holds the pc, the inflight/tag registers, the issue/credit logic and the redirect priority.

## Test plan
- Reset then free run, out_ready=1, DEPTH=4, RESET_PC=0:
  - imem_addr sequence 0, 4, 8, … from the first post-reset cycle.
  - out_valid rises in cycle 2.
  - out_pc 0, 4, 8 on consecutive cycles.
- Backpressure: out_ready=0 from cycle 3:
  - count saturates at 4 and imem_req drops.
  - Raise out_ready: 0x0, 0x4, … drain in order with no gap, duplicate or loss.
- Redirect to 0x100 while count=3 and a request is inflight:
  - Next cycle count=0, out_valid=0, imem_addr=0x100.
  - out_pc=0x100 three cycles after the redirect.
  - The stale response never appears.
- redirect_pc=0x103 together with pop=1: fetch resumes at 0x100 and count=0.
- Wrap-around with XLEN=32, RESET_PC=0xFFFFFFF8: addresses FFFFFFF8, FFFFFFFC, 00000000, in order.
- rst asserted for one cycle mid-stream with count=2 and inflight=1:
  - Next cycle count=0, out_valid=0.
  - Fetch restarts at RESET_PC.
  - Repeat the free-run check with DEPTH=2 for 1/cycle throughput.
